// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - half/full period meter with lock and stall flags for a slow async clock
`timescale 1ns/1ps
module clk_period_meter #(
    parameter int CNT_W       = 25,
    parameter int EXPECT_HALF = 25000,
    parameter int TOL         = 16,
    parameter int LOCK_N      = 4,
    parameter int TIMEOUT     = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_clk,
    output logic [CNT_W-1:0] half_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             locked,
    output logic             stalled
);
    localparam int               RUN_W     = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] EXPECT_C  = CNT_W'(EXPECT_HALF);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_N);

    typedef enum logic [1:0] {IDLE, ACQ, MEAS, RUN} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             in_edge, in_rise, in_tol, measure, timeout;
    logic [CNT_W-1:0] cnt, cnt_nxt, diff;
    logic [CNT_W-1:0] hi_half, hi_half_nxt, half_nxt, period_nxt;
    logic             hi_vld, hi_vld_nxt, valid_nxt, locked_nxt, stalled_nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;

    assign in_edge = s2 ^ s3;
    assign in_rise = s2 & ~s3;
    assign diff    = (cnt >= EXPECT_C) ? cnt - EXPECT_C : EXPECT_C - cnt;
    assign in_tol  = (diff <= TOL_C);
    assign measure = in_edge && (state == MEAS || state == RUN);
    // an edge in the same cycle as the timeout hit keeps the meter running
    assign timeout = (state != IDLE) && !in_edge && (cnt == TIMEOUT_C);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_half_nxt = hi_half;
        hi_vld_nxt  = hi_vld;
        half_nxt    = half_cnt;
        period_nxt  = period_cnt;
        valid_nxt   = 1'b0;
        locked_nxt  = locked;
        stalled_nxt = stalled;
        run_nxt     = run_cnt;
        if (!en) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            hi_vld_nxt  = 1'b0;
            locked_nxt  = 1'b0;
            stalled_nxt = 1'b0;
            run_nxt     = '0;
        end else begin
            if (in_edge)
                cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
            else if (cnt != CNT_MAX)
                cnt_nxt = cnt + 1'b1;
            case (state)
                IDLE:    state_nxt = ACQ;
                ACQ:     if (in_edge) state_nxt = MEAS;
                MEAS:    if (in_edge) state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
            if (in_edge)
                stalled_nxt = 1'b0;
            if (measure) begin
                half_nxt = cnt;
                if (in_tol) begin
                    run_nxt    = (run_cnt == LOCK_C) ? run_cnt : run_cnt + 1'b1;
                    locked_nxt = (run_nxt == LOCK_C);
                end else begin
                    run_nxt    = '0;
                    locked_nxt = 1'b0;
                end
            end
            // a period is a high half followed by its low half, closed on the rise
            if (in_edge && state == RUN) begin
                if (!in_rise) begin
                    hi_half_nxt = cnt;
                    hi_vld_nxt  = 1'b1;
                end else if (hi_vld) begin
                    period_nxt = hi_half + cnt;
                    valid_nxt  = 1'b1;
                end
            end
            if (timeout) begin
                state_nxt   = ACQ;
                stalled_nxt = 1'b1;
                locked_nxt  = 1'b0;
                run_nxt     = '0;
                hi_vld_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            hi_half    <= '0;
            hi_vld     <= 1'b0;
            half_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            stalled    <= 1'b0;
            run_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            s1         <= in_clk;
            s2         <= s1;
            s3         <= s2;
            cnt        <= cnt_nxt;
            hi_half    <= hi_half_nxt;
            hi_vld     <= hi_vld_nxt;
            half_cnt   <= half_nxt;
            period_cnt <= period_nxt;
            valid      <= valid_nxt;
            locked     <= locked_nxt;
            stalled    <= stalled_nxt;
            run_cnt    <= run_nxt;
        end
    end
endmodule
